regfile_sb: RTL
===============

# regfile_sb

Parametrised integer register file with configurable width, depth and read-port count, same-cycle write-to-read bypass and a per-register pending-write scoreboard. It replaces the fixed 2-read/1-write, 32×32 register file in the pipelined core. Decode issues destination registers into the scoreboard. Writeback retires them. Read ports report both data and a busy flag, so the hazard unit can stall without keeping its own tracking.

## Interface
- XLEN, 32: data width of each register.
- NREGS, 32: number of registers, a power of two ≥ 2. Register 0 is hardwired to zero.
- NREAD, 2: number of read ports, ≥ 1.
- CW, 2: width of each pending-write counter. Up to 2^CW−1 outstanding writes per register.
- AW, $clog2(NREGS): address width, derived and not overridden.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_raddr  in  NREAD*AW  read addresses; port k is bits [k*AW +: AW].
- o_rdata  out  NREAD*XLEN  read data per port; combinational.
- o_rbusy  out  NREAD  per port, high when the addressed register still has a pending write.
- i_write  in  1  writeback valid.
- i_waddr  in  AW  writeback address.
- i_wdata  in  XLEN  writeback data.
- i_issue  in  1  issue valid; marks i_issue_rd as having one more pending write.
- i_issue_rd  in  AW  destination register of the issued instruction.
- o_issue_stall  out  1  high when i_issue_rd's counter is saturated; the issue is then ignored.
- o_busy  out  NREGS  per-register busy (counter ≠ 0, registered view); bit 0 is always 0.
- o_regs  out  NREGS*XLEN  flattened snapshot of the registered contents; slice 0 is always 0.

## Operation
- Storage: registers 1..NREGS−1, each XLEN bits. Register 0 has no storage.
- Reset (i_rst_n low, asynchronous): all registers clear to 0 and all counters clear to 0. Consequently o_busy = 0, o_regs = 0, and o_rbusy = 0 and o_issue_stall = 0 for any address.
- Write: when i_write is high and i_waddr ≠ 0, registers[i_waddr] takes i_wdata at the edge. A write to address 0 is discarded.
- Read, port k:
  - If the address is 0, rdata = 0.
  - Else if i_write is high and i_waddr equals the address, rdata = i_wdata (bypass).
  - Else rdata = registers[address].
- Counter update for register r ≠ 0 at each edge:
  - inc = i_issue && i_issue_rd == r && !o_issue_stall.
  - dec = i_write && i_waddr == r && cnt[r] ≠ 0.
  - Next value = cnt + inc − dec.
  - Both inc and dec in the same cycle leave the counter unchanged.
- A write to a register whose counter is 0 updates data and leaves the counter at 0. This is an untracked write, e.g. from a debug path.
- Issue to register 0 never increments and never stalls.
- o_issue_stall = i_issue && i_issue_rd ≠ 0 && cnt[i_issue_rd] == 2^CW−1 && !(i_write && i_waddr == i_issue_rd). A same-cycle retire frees a slot, so there is no stall in that case.
- o_rbusy[k] = (cnt[a] − dec_a) ≠ 0, where a is port k's address. A last pending write retiring this cycle therefore reads as not busy together with the bypassed data. Issues in the current cycle do not affect o_rbusy.

## Timing
- Read data, o_rbusy and o_issue_stall are combinational from their inputs and the current state, with zero latency.
- Write data appears in registers and o_regs one edge after i_write. The bypass makes it visible on read ports in the same cycle.
- An issue becomes visible on o_busy and o_rbusy from the edge after it is accepted.
- Reset asserted mid-operation clears everything immediately, regardless of in-flight i_write or i_issue. The first edge after i_rst_n rises applies inputs normally.
- Every read port may address the same register without conflict. All ports see identical data.

## Test plan
- Reset:
  - Stimulus: write 0xDEADBEEF to r5, issue r5, then pulse i_rst_n low between edges.
  - Required: o_regs[5] = 0, o_busy = 0 immediately, without waiting for a clock edge.
- Bypass:
  - Stimulus: i_write=1, i_waddr=7, i_wdata=0x12345678, both read ports at address 7, in the same cycle.
  - Required: both rdata = 0x12345678. The next cycle, with i_write=0, still reads 0x12345678.
- Register 0:
  - Stimulus: write 0xFFFFFFFF to r0, then issue r0.
  - Required: rdata = 0, o_busy[0] = 0, o_issue_stall = 0.
- Scoreboard:
  - Stimulus: issue r3 three times (CW=2), then a fourth time.
  - Required: stall on the fourth issue, with cnt staying 3. Then write r3 and issue r3 in the same cycle: no stall, cnt stays 3. Then three writes to r3: o_rbusy drops in the cycle of the third write.
- Untracked write:
  - Stimulus: write r9 with cnt = 0.
  - Required: data updates, o_busy[9] stays 0.
- Parametrisation:
  - Configuration: XLEN=64, NREGS=16, NREAD=3.
  - Stimulus: three ports read r15, r1, r0 after writing 64'hA5A5_0000_FFFF_0001 to r15.
  - Required: correct data on each port, with port 2 returning 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised register file with same-cycle write bypass and a per-register
// pending-write scoreboard feeding the hazard unit.
module regfile_sb #(
   parameter  int unsigned XLEN  = 32,
   parameter  int unsigned NREGS = 32,
   parameter  int unsigned NREAD = 2,
   parameter  int unsigned CW    = 2,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NREAD*AW-1:0]   i_raddr,
   output logic [NREAD*XLEN-1:0] o_rdata,
   output logic [NREAD-1:0]      o_rbusy,
   input  logic                  i_write,
   input  logic [AW-1:0]         i_waddr,
   input  logic [XLEN-1:0]       i_wdata,
   input  logic                  i_issue,
   input  logic [AW-1:0]         i_issue_rd,
   output logic                  o_issue_stall,
   output logic [NREGS-1:0]      o_busy,
   output logic [NREGS*XLEN-1:0] o_regs
);

   localparam logic [CW-1:0] CntMax = '1;

   logic [XLEN-1:0] regs_q [NREGS-1:1];
   logic [XLEN-1:0] regs_d [NREGS-1:1];
   logic [CW-1:0]   cnt_q  [NREGS-1:1];
   logic [CW-1:0]   cnt_d  [NREGS-1:1];

   // Full-range views with a constant-zero entry 0, so any address can index them.
   logic [XLEN-1:0] regs_view [NREGS];
   logic [CW-1:0]   cnt_view  [NREGS];

   logic wr_hit_issue;
   logic issue_ok;

   always_comb begin
      regs_view[0] = '0;
      cnt_view[0]  = '0;
      for (int unsigned r = 1; r < NREGS; r++) begin
         regs_view[r] = regs_q[r];
         cnt_view[r]  = cnt_q[r];
      end
   end

   // A retire to the same register this cycle frees a slot, so no stall then.
   assign wr_hit_issue  = i_write && (i_waddr == i_issue_rd);
   assign o_issue_stall = i_issue && (i_issue_rd != '0) &&
                          (cnt_view[i_issue_rd] == CntMax) && !wr_hit_issue;
   assign issue_ok      = i_issue && !o_issue_stall;

   always_comb begin
      regs_d = regs_q;
      cnt_d  = cnt_q;
      for (int unsigned r = 1; r < NREGS; r++) begin
         if (i_write && (i_waddr == AW'(r))) begin
            regs_d[r] = i_wdata;
         end
         cnt_d[r] = cnt_q[r]
                  + CW'(issue_ok && (i_issue_rd == AW'(r)))
                  - CW'(i_write && (i_waddr == AW'(r)) && (cnt_q[r] != '0));
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned r = 1; r < NREGS; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      o_busy = '0;
      o_regs = '0;
      for (int unsigned r = 1; r < NREGS; r++) begin
         o_busy[r]                = (cnt_q[r] != '0);
         o_regs[r*XLEN +: XLEN]   = regs_q[r];
      end
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          wr_hit;

      assign addr   = i_raddr[k*AW +: AW];
      assign wr_hit = i_write && (i_waddr == addr);

      assign o_rdata[k*XLEN +: XLEN] = (addr == '0) ? '0 :
                                       wr_hit       ? i_wdata :
                                                      regs_view[addr];
      // A last pending write retiring now reads as not busy alongside the bypass.
      assign o_rbusy[k] =
         (cnt_view[addr] - CW'(wr_hit && (cnt_view[addr] != '0))) != '0;
   end

endmodule
